// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control sequencer.
// Holds the state enum, opcode/instruction classes, ALU, pc_src and trap-cause codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LD, CL_ST, CL_BR, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILL
    } iclass_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1101;
    localparam logic [3:0] ALU_BLTU = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic iclass_t classify(input logic [6:0] op);
        iclass_t c;
        case (op)
            OP_R:     c = CL_R;
            OP_I:     c = CL_I;
            OP_LD:    c = CL_LD;
            OP_ST:    c = CL_ST;
            OP_BR:    c = CL_BR;
            OP_JAL:   c = CL_JAL;
            OP_JALR:  c = CL_JALR;
            OP_LUI:   c = CL_LUI;
            OP_AUIPC: c = CL_AUIPC;
            default:  c = CL_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU operation decode from opcode/Funct3/Funct7.
// Only Funct7[5] is architecturally meaningful (SUB for R-type, SRA for both shift forms).
module multicycle_ctrl_alu_decoder
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_CC_W = 4
) (
    input  logic [6:0]          opcode,
    input  logic [2:0]          Funct3,
    input  logic [6:0]          Funct7,
    output logic [ALU_CC_W-1:0] ALU_CC
);

    iclass_t    cls;
    logic       alt;
    logic [3:0] cc;
    logic       unused_funct7;

    assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

    always_comb begin
        cls = classify(opcode);
        alt = Funct7[5];
        cc  = ALU_ADD;
        case (cls)
            CL_R, CL_I: begin
                case (Funct3)
                    3'b000:  cc = (cls == CL_R && alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  cc = ALU_SLL;
                    3'b010:  cc = ALU_SLT;
                    3'b011:  cc = ALU_SLTU;
                    3'b100:  cc = ALU_XOR;
                    3'b101:  cc = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  cc = ALU_OR;
                    default: cc = ALU_AND;
                endcase
            end
            CL_BR: begin
                case (Funct3)
                    3'b001:  cc = ALU_BNE;
                    3'b100:  cc = ALU_BLT;
                    3'b101:  cc = ALU_BGE;
                    3'b110:  cc = ALU_BLTU;
                    3'b111:  cc = ALU_BGEU;
                    default: cc = ALU_BEQ;
                endcase
            end
            default: cc = ALU_ADD;
        endcase
        ALU_CC = ALU_CC_W'(cc);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory wait states,
// retired-instruction counter and a sticky illegal-opcode / dmem-timeout trap.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALU_CC_W    = 4,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [2:0]          Funct3,
    input  logic [6:0]          Funct7,
    input  logic                branch_taken,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic [1:0]          pc_src,
    output logic                RegWrite,
    output logic                MemtoReg,
    output logic                ALUsrc,
    output logic                MemWrite,
    output logic                MemRead,
    output logic                Branch,
    output logic                AUIPC,
    output logic                SrcA_zero,
    output logic [ALU_CC_W-1:0] ALU_CC,
    output logic                retire,
    output logic [CNT_W-1:0]    instret,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    state_t              state, state_nx;
    iclass_t             cls;
    logic [ALU_CC_W-1:0] alu_cc;
    logic [7:0]          wcnt;
    logic                trap_set;
    logic [1:0]          trap_code;

    multicycle_ctrl_alu_decoder #(.ALU_CC_W(ALU_CC_W)) u_alu_decoder (
        .opcode (opcode),
        .Funct3 (Funct3),
        .Funct7 (Funct7),
        .ALU_CC (alu_cc)
    );

    assign cls = classify(opcode);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            instret    <= '0;
            trap       <= 1'b0;
            trap_cause <= CAUSE_NONE;
            wcnt       <= '0;
        end else begin
            state <= state_nx;
            if (retire)
                instret <= instret + CNT_W'(1);
            if (trap_set) begin
                trap       <= 1'b1;
                trap_cause <= trap_code;
            end
            if (state == MEM && state_nx == MEM)
                wcnt <= wcnt + 8'd1;
            else
                wcnt <= '0;
        end
    end

    always_comb begin
        state_nx  = state;
        trap_set  = 1'b0;
        trap_code = CAUSE_NONE;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        pc_src    = PC_PLUS4;
        RegWrite  = 1'b0;
        MemtoReg  = 1'b0;
        ALUsrc    = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Branch    = 1'b0;
        AUIPC     = 1'b0;
        SrcA_zero = 1'b0;
        ALU_CC    = '0;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                // reset gates the only input-driven output so all outputs clear while reset is low
                IRWrite = imem_ready & reset;
                if (imem_ready)
                    state_nx = DECODE;
            end
            DECODE: begin
                if (cls == CL_ILL) begin
                    state_nx  = TRAP;
                    trap_set  = 1'b1;
                    trap_code = CAUSE_ILLEGAL;
                end else begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                ALU_CC    = alu_cc;
                ALUsrc    = !(cls == CL_R || cls == CL_BR);
                AUIPC     = (cls == CL_AUIPC || cls == CL_JAL);
                SrcA_zero = (cls == CL_LUI);
                case (cls)
                    CL_BR: begin
                        Branch   = 1'b1;
                        PCWrite  = 1'b1;
                        pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
                        retire   = 1'b1;
                        state_nx = FETCH;
                    end
                    CL_JAL, CL_JALR: begin
                        Branch   = 1'b1;
                        RegWrite = 1'b1;
                        PCWrite  = 1'b1;
                        pc_src   = PC_ALU;
                        retire   = 1'b1;
                        state_nx = FETCH;
                    end
                    CL_LD, CL_ST: state_nx = MEM;
                    default:      state_nx = WB;
                endcase
            end
            MEM: begin
                MemRead  = (cls == CL_LD);
                MemWrite = (cls == CL_ST);
                // a completion on the final allowed cycle takes priority over the timeout
                if (dmem_ready) begin
                    if (cls == CL_LD) begin
                        state_nx = WB;
                    end else begin
                        PCWrite  = 1'b1;
                        retire   = 1'b1;
                        state_nx = FETCH;
                    end
                end else if (wcnt == 8'(MEM_TIMEOUT - 1)) begin
                    state_nx  = TRAP;
                    trap_set  = 1'b1;
                    trap_code = CAUSE_TIMEOUT;
                end
            end
            WB: begin
                RegWrite = 1'b1;
                MemtoReg = (cls == CL_LD);
                PCWrite  = 1'b1;
                retire   = 1'b1;
                state_nx = FETCH;
            end
            default: state_nx = TRAP;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed and random instructions checked cycle by cycle
// against a per-instruction schedule built from the instruction's class and wait delays.
module tb_multicycle_ctrl;

    localparam int TMO = 15;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic [1:0] pcs;
        logic       rw;
        logic       m2r;
        logic       asrc;
        logic       mw;
        logic       mr;
        logic       br;
        logic       aui;
        logic       sz;
        logic [3:0] cc;
        logic       ret;
        logic       trp;
        logic [1:0] tc;
    } ovec_t;

    typedef struct packed {
        logic  im;
        logic  dm;
        logic  bt;
        ovec_t o;
    } step_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        branch_taken, imem_ready, dmem_ready;

    logic        IRWrite, PCWrite, RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead;
    logic        Branch, AUIPC, SrcA_zero, retire, trap;
    logic [1:0]  pc_src, trap_cause;
    logic [3:0]  ALU_CC;
    logic [31:0] instret;

    logic        IRWrite_w, PCWrite_w, RegWrite_w, MemtoReg_w, ALUsrc_w, MemWrite_w, MemRead_w;
    logic        Branch_w, AUIPC_w, SrcA_zero_w, retire_w, trap_w;
    logic [1:0]  pc_src_w, trap_cause_w;
    logic [3:0]  ALU_CC_w;
    logic [3:0]  instret_w;

    ovec_t obs, obs_w;
    int    checks = 0;
    int    errors = 0;
    logic [31:0] exp_instret;
    logic [3:0]  exp_instret_w;

    logic [6:0] ops   [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic [2:0] brf3  [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .pc_src(pc_src), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .ALUsrc(ALUsrc), .MemWrite(MemWrite), .MemRead(MemRead),
        .Branch(Branch), .AUIPC(AUIPC), .SrcA_zero(SrcA_zero), .ALU_CC(ALU_CC),
        .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    multicycle_ctrl #(.ALU_CC_W(4), .CNT_W(4), .MEM_TIMEOUT(TMO)) dut_w (
        .clk(clk), .reset(reset), .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .IRWrite(IRWrite_w), .PCWrite(PCWrite_w), .pc_src(pc_src_w), .RegWrite(RegWrite_w),
        .MemtoReg(MemtoReg_w), .ALUsrc(ALUsrc_w), .MemWrite(MemWrite_w), .MemRead(MemRead_w),
        .Branch(Branch_w), .AUIPC(AUIPC_w), .SrcA_zero(SrcA_zero_w), .ALU_CC(ALU_CC_w),
        .retire(retire_w), .instret(instret_w), .trap(trap_w), .trap_cause(trap_cause_w)
    );

    assign obs   = {IRWrite, PCWrite, pc_src, RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead,
                    Branch, AUIPC, SrcA_zero, ALU_CC, retire, trap, trap_cause};
    assign obs_w = {IRWrite_w, PCWrite_w, pc_src_w, RegWrite_w, MemtoReg_w, ALUsrc_w, MemWrite_w,
                    MemRead_w, Branch_w, AUIPC_w, SrcA_zero_w, ALU_CC_w, retire_w, trap_w, trap_cause_w};

    task automatic check_vec(input string tag, input ovec_t got, input ovec_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // ALU code expected from the RV32I instruction table
    function automatic logic [3:0] ref_alu(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7);
        logic [3:0] r;
        r = 4'd2;
        if (op == 7'h33 || op == 7'h13) begin
            case (f3)
                3'd0: r = (op == 7'h33 && f7[5]) ? 4'd6 : 4'd2;
                3'd1: r = 4'd4;
                3'd2: r = 4'd7;
                3'd3: r = 4'd9;
                3'd4: r = 4'd3;
                3'd5: r = f7[5] ? 4'd8 : 4'd5;
                3'd6: r = 4'd1;
                default: r = 4'd0;
            endcase
        end else if (op == 7'h63) begin
            case (f3)
                3'd1: r = 4'd11;
                3'd4: r = 4'd12;
                3'd5: r = 4'd13;
                3'd6: r = 4'd14;
                3'd7: r = 4'd15;
                default: r = 4'd10;
            endcase
        end
        return r;
    endfunction

    function automatic step_t rnd_step();
        step_t s;
        s    = '0;
        s.im = 1'($urandom);
        s.dm = 1'($urandom);
        s.bt = 1'($urandom);
        return s;
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        #2 reset   = 1'b0;
        imem_ready = 1'b1;
        #1;
        check_vec("reset_outputs", obs, '0);
        check_vec("reset_outputs_w", obs_w, '0);
        check_val("reset_instret", instret, 32'd0);
        check_val("reset_instret_w", {28'd0, instret_w}, 32'd0);
        exp_instret   = '0;
        exp_instret_w = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // fd: cycles imem_ready stays low; dd: MEM cycles dmem_ready stays low
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int fd, input int dd, input logic bt);
        step_t s;
        step_t q[$];
        bit is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui, legal, trapped;
        logic [1:0] cause;
        ovec_t tv;
        is_r = (op == 7'h33); is_i = (op == 7'h13); is_ld = (op == 7'h03);
        is_st = (op == 7'h23); is_br = (op == 7'h63); is_jal = (op == 7'h6F);
        is_jalr = (op == 7'h67); is_lui = (op == 7'h37); is_aui = (op == 7'h17);
        legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui | is_aui;
        trapped = 0;
        cause = 2'b00;
        for (int i = 0; i <= fd; i++) begin
            s = rnd_step();
            s.im = (i == fd);
            s.o.irw = (i == fd);
            q.push_back(s);
        end
        q.push_back(rnd_step());
        if (!legal) begin
            trapped = 1;
            cause = 2'b01;
        end else begin
            s = rnd_step();
            s.o.cc = ref_alu(op, f3, f7);
            s.o.asrc = !(is_r || is_br);
            s.o.aui = is_aui || is_jal;
            s.o.sz = is_lui;
            if (is_br) begin
                s.bt = bt; s.o.br = 1; s.o.pcw = 1; s.o.pcs = bt ? 2'b01 : 2'b00; s.o.ret = 1;
            end else if (is_jal || is_jalr) begin
                s.o.br = 1; s.o.rw = 1; s.o.pcw = 1; s.o.pcs = 2'b10; s.o.ret = 1;
            end
            q.push_back(s);
            if (is_ld || is_st) begin
                for (int j = 0; j < TMO; j++) begin
                    s = rnd_step();
                    s.o.mr = is_ld;
                    s.o.mw = is_st;
                    s.dm = (j >= dd);
                    if (s.dm && is_st) begin
                        s.o.pcw = 1; s.o.ret = 1;
                    end
                    q.push_back(s);
                    if (s.dm) break;
                    if (j == TMO - 1) begin
                        trapped = 1;
                        cause = 2'b10;
                    end
                end
            end
            if (!trapped && (is_r || is_i || is_lui || is_aui || is_ld)) begin
                s = rnd_step();
                s.o.rw = 1; s.o.m2r = is_ld; s.o.pcw = 1; s.o.ret = 1;
                q.push_back(s);
            end
        end
        opcode = op; Funct3 = f3; Funct7 = f7;
        foreach (q[k]) begin
            imem_ready = q[k].im;
            dmem_ready = q[k].dm;
            branch_taken = q[k].bt;
            #1;
            check_vec(tag, obs, q[k].o);
            check_vec({tag, "_w"}, obs_w, q[k].o);
            if (q[k].o.ret) begin
                exp_instret++;
                exp_instret_w++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check_val({tag, "_instret"}, instret, exp_instret);
        check_val({tag, "_instret_w"}, {28'd0, instret_w}, {28'd0, exp_instret_w});
        if (trapped) begin
            tv = '0;
            tv.trp = 1'b1;
            tv.tc = cause;
            for (int k = 0; k < 3; k++) begin
                s = rnd_step();
                imem_ready = s.im; dmem_ready = s.dm; branch_taken = s.bt;
                #1;
                check_vec({tag, "_trapped"}, obs, tv);
                @(posedge clk);
                @(negedge clk);
            end
            check_val({tag, "_trap_instret"}, instret, exp_instret);
        end
    endtask

    initial begin
        opcode = '0; Funct3 = '0; Funct7 = '0;
        branch_taken = 0; imem_ready = 0; dmem_ready = 0;
        reset = 1'b1;
        exp_instret = '0;
        exp_instret_w = '0;
        @(negedge clk);
        do_reset();

        run_instr("add", 7'h33, 3'd0, 7'h00, 0, 0, 1'b0);
        run_instr("add_fetchwait", 7'h33, 3'd0, 7'h00, 2, 0, 1'b0);
        run_instr("sub", 7'h33, 3'd0, 7'h20, 0, 0, 1'b0);
        run_instr("srai", 7'h13, 3'd5, 7'h20, 0, 0, 1'b0);
        run_instr("addi_f7", 7'h13, 3'd0, 7'h20, 0, 0, 1'b0);
        run_instr("beq_taken", 7'h63, 3'd0, 7'h00, 0, 0, 1'b1);
        run_instr("bne_not", 7'h63, 3'd1, 7'h00, 0, 0, 1'b0);
        run_instr("jal", 7'h6F, 3'd0, 7'h00, 0, 0, 1'b0);
        run_instr("jalr", 7'h67, 3'd0, 7'h00, 0, 0, 1'b0);
        run_instr("lui", 7'h37, 3'd3, 7'h00, 0, 0, 1'b0);
        run_instr("auipc", 7'h17, 3'd3, 7'h00, 0, 0, 1'b0);
        run_instr("lw_wait3", 7'h03, 3'd2, 7'h00, 0, 3, 1'b0);
        run_instr("sw", 7'h23, 3'd2, 7'h00, 0, 0, 1'b0);
        run_instr("sw_last_cycle", 7'h23, 3'd2, 7'h00, 0, TMO - 1, 1'b0);
        run_instr("lw_last_cycle", 7'h03, 3'd2, 7'h00, 1, TMO - 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = ops[$urandom_range(8)];
            f3 = (op == 7'h63) ? brf3[$urandom_range(5)] : 3'($urandom);
            run_instr("rand", op, f3, 7'($urandom), int'($urandom_range(2)),
                      int'($urandom_range(4)), 1'($urandom));
        end

        run_instr("sw_timeout", 7'h23, 3'd2, 7'h00, 0, 1000, 1'b0);
        do_reset();
        run_instr("illegal", 7'h7F, 3'd0, 7'h00, 0, 0, 1'b0);
        do_reset();

        // reset asserted while a store is stalled in MEM
        run_instr("pre_add", 7'h33, 3'd7, 7'h00, 0, 0, 1'b0);
        opcode = 7'h23; Funct3 = 3'd2; Funct7 = '0;
        imem_ready = 1'b1; dmem_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("mid_mem_memwrite", {31'd0, MemWrite}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_vec("mid_mem_reset", obs, '0);
        check_val("mid_mem_instret", instret, 32'd0);
        exp_instret = '0;
        exp_instret_w = '0;
        @(negedge clk);
        reset = 1'b1;
        run_instr("post_reset_add", 7'h33, 3'd0, 7'h00, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
